booth_mul_arbiter: RTL
======================

Name: booth_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one signed Booth multiplier among NUM_REQ requesters. Each requester offers an operand pair through a valid/ready handshake. The block registers the granted operands onto the multiplier inputs and waits a programmable settle/pipeline latency. It then returns the 2W-bit signed product, tagged with the requester ID, through a valid/ready response port. It sits between the client blocks and the booth_multiplier instance. At most one operation is in flight.

Parameters:
NUM_REQ, 4, number of requesters (>=2); ID width IDW = $clog2(NUM_REQ)
W, 8, operand width; product width 2W
MUL_LAT, 0, extra multiplier cycles beyond one (0 = combinational multiplier)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*W  packed signed multiplicands, requester i at [i*W +: W]
req_b  in  NUM_REQ*W  packed signed multipliers, same packing
mul_a  out  W  registered operand to multiplier port a
mul_b  out  W  registered operand to multiplier port b
mul_out  in  2W  signed product from multiplier
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted by consumer
rsp_id  out  IDW  index of requester owning rsp_data
rsp_data  out  2W  signed product

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, cnt=0.
  - mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - req_ready=0 while rst is high.
  - An operation in progress is abandoned; no response is produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other bits are 0.
  - On that edge:
    - mul_a <= req_a[grant], mul_b <= req_b[grant], rsp_id <= grant.
    - rr_ptr <= (grant+1) mod NUM_REQ, cnt <= MUL_LAT, next state WAIT.
  - If no req_valid is set, stay in IDLE and rr_ptr is unchanged.
- WAIT:
  - req_ready=0; mul_a and mul_b are held stable.
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0: rsp_data <= mul_out, rsp_valid <= 1, next state RESP.
  - WAIT lasts exactly MUL_LAT+1 cycles.
- RESP:
  - req_ready=0; rsp_valid, rsp_id and rsp_data are held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid <= 0, next state IDLE.
  - rsp_data and rsp_id keep their last values after the handshake.
- Latency and throughput:
  - Request accepted in cycle T gives rsp_valid high from cycle T+MUL_LAT+2.
  - Back-to-back throughput is one operation per MUL_LAT+3 cycles when rsp_ready is held high.
- Arithmetic:
  - Product is passed through unmodified (signed 2W); the block performs no arithmetic.
  - mul_a and mul_b keep the last operands between operations.
- Boundaries:
  - req_valid may drop without ready; nothing is latched and no error is raised.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - rsp_ready high while rsp_valid is low is ignored.
  - Simultaneous requests are resolved purely by rr_ptr order.
  - rst asserted in any state overrides all other activity that cycle.

Test Plan:
1. Reset, then req 0 only: a=0xBA, b=0xBA (-70*-70), MUL_LAT=0, rsp_ready=1 -> req_ready[0] high in the accept cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_data=16'd4900.
2. All four valid after reset with operands (-69,40), (9,0), (1,1), (28,7) -> grants in order 0,1,2,3; responses -2760, 0, 1, 196 with ids 0..3; each accept 3 cycles apart.
3. Fairness: req0 and req2 held continuously valid -> grants alternate 0,2,0,2; req1 and req3 never granted.
4. Backpressure: req1 = (-111,41), rsp_ready low for 5 cycles after rsp_valid -> rsp_valid, rsp_id=1 and rsp_data=-4551 stable; req_ready stays 0 despite other valids; IDLE resumes one cycle after rsp_ready rises.
5. MUL_LAT=2, req3 = (8,-30) -> mul_a/mul_b stable for 3 WAIT cycles; rsp_valid 4 cycles after accept; rsp_data=-240.
6. rst pulsed for one cycle while in WAIT -> no rsp_valid; all outputs 0; rr_ptr=0; the next request from req2 is granted normally.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that time-shares one signed multiplier among NUM_REQ requesters.
// Granted operands are registered onto the multiplier; the product returns after MUL_LAT+1 wait cycles.
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 0,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*W-1:0]       rsp_data
);

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam int IW = IDW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mul_a_q, mul_a_d;
  logic [W-1:0]   mul_b_q, mul_b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [2*W-1:0] rsp_data_q, rsp_data_d;

  logic [W-1:0]   op_a [NUM_REQ];
  logic [W-1:0]   op_b [NUM_REQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*W +: W];
      assign op_b[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // Priority search starting at rr_ptr and wrapping modulo NUM_REQ.
  always_comb begin
    logic [IW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + IW'(k);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      if (!grant_found && req_valid[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          mul_a_d  = op_a[grant_idx];
          mul_b_d  = op_b[grant_idx];
          rsp_id_d = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d    = CW'(MUL_LAT);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = mul_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant during reset would be lost, so never advertise one.
    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
